// File: rtl/sr_mem_pkg.sv
// Shared types and defaults for the store buffer: the buffered entry layout and the byte-to-word
// address helper used for both storage and forwarding lookups.
package sr_mem_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:2] waddr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  function automatic logic [SB_ADDR_W-1:2] word_addr(input logic [SB_ADDR_W-1:0] byte_addr);
    return byte_addr[SB_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/sr_sb_match.sv
// Youngest-match priority finder: scans entries backwards from the write pointer and reports the
// first valid entry whose word address equals the lookup address.
module sr_sb_match #(
  parameter int DEPTH  = 4,
  parameter int WA_W   = 30,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic [WA_W-1:0]  i_waddr [DEPTH],
  input  logic [DEPTH-1:0] i_valid,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [WA_W-1:0]  i_lookup,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    o_hit = 1'b0;
    o_idx = '0;
    cand  = '0;
    // k=1 is the most recent push; modular subtraction handles the wrap
    for (int k = 1; k <= DEPTH; k++) begin
      cand = i_wr_idx - IDX_W'(k);
      if (!o_hit && i_valid[cand] && (i_waddr[cand] == i_lookup)) begin
        o_hit = 1'b1;
        o_idx = cand;
      end
    end
  end

endmodule

// File: rtl/sr_store_buffer.sv
// Posted-write store buffer: zero-wait-state store FIFO drained to the RAM write port, with
// store-to-load forwarding (youngest match wins) and a sticky overflow flag instead of back-pressure.
module sr_store_buffer
  import sr_mem_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        cpuAddr,
  input  logic                     cpuWe,
  input  logic [DATA_W-1:0]        cpuWData,
  output logic [DATA_W-1:0]        cpuRData,
  output logic [ADDR_W-1:0]        memRAddr,
  input  logic [DATA_W-1:0]        memRData,
  output logic                     memWValid,
  input  logic                     memWReady,
  output logic [ADDR_W-1:0]        memWAddr,
  output logic [DATA_W-1:0]        memWData,
  output logic                     sbEmpty,
  output logic                     sbFull,
  output logic [$clog2(DEPTH):0]   sbCount,
  output logic                     sbOverflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [DEPTH-1:0] r_valid;
  logic             r_overflow;
  sb_entry_t        r_mem [DEPTH];

  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_hit;
  logic [IDX_W-1:0] w_hit_idx;
  logic [WA_W-1:0]  w_waddr [DEPTH];

  assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
  assign w_rd_idx = r_rd_ptr[IDX_W-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) && (w_wr_idx == w_rd_idx);
  assign w_pop    = ~w_empty & memWReady;
  // a full buffer still accepts a store when the head drains in the same cycle
  assign w_push   = cpuWe & (~w_full | w_pop);
  assign w_drop   = cpuWe & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_valid    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr           <= r_rd_ptr + PTR_W'(1);
        r_valid[w_rd_idx]  <= 1'b0;
      end
      // when full, pop and push hit the same slot; the later assignment keeps it valid
      if (w_push) begin
        r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
        r_valid[w_wr_idx]  <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= '{waddr: word_addr(cpuAddr), data: cpuWData};
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_waddr[i] = r_mem[i].waddr;
    end
  end

  sr_sb_match #(
    .DEPTH (DEPTH),
    .WA_W  (WA_W),
    .IDX_W (IDX_W)
  ) u_match (
    .i_waddr  (w_waddr),
    .i_valid  (r_valid),
    .i_wr_idx (w_wr_idx),
    .i_lookup (word_addr(cpuAddr)),
    .o_hit    (w_hit),
    .o_idx    (w_hit_idx)
  );

  assign cpuRData   = w_hit ? r_mem[w_hit_idx].data : memRData;
  assign memRAddr   = cpuAddr;
  assign memWValid  = ~w_empty;
  assign memWAddr   = {r_mem[w_rd_idx].waddr, 2'b00};
  assign memWData   = r_mem[w_rd_idx].data;
  assign sbEmpty    = w_empty;
  assign sbFull     = w_full;
  assign sbCount    = r_wr_ptr - r_rd_ptr;
  assign sbOverflow = r_overflow;

endmodule

// File: tb/tb_sr_store_buffer.sv
// Directed bench for sr_store_buffer: reset, push/drain, forwarding, wrap, full/overflow and
// same-cycle store/load behaviour, all against hand-computed values.
module tb_sr_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpuAddr;
  logic        cpuWe;
  logic [31:0] cpuWData;
  logic [31:0] cpuRData;
  logic [31:0] memRAddr;
  logic [31:0] memRData;
  logic        memWValid;
  logic        memWReady;
  logic [31:0] memWAddr;
  logic [31:0] memWData;
  logic        sbEmpty;
  logic        sbFull;
  logic [2:0]  sbCount;
  logic        sbOverflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sr_store_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .cpuAddr    (cpuAddr),
    .cpuWe      (cpuWe),
    .cpuWData   (cpuWData),
    .cpuRData   (cpuRData),
    .memRAddr   (memRAddr),
    .memRData   (memRData),
    .memWValid  (memWValid),
    .memWReady  (memWReady),
    .memWAddr   (memWAddr),
    .memWData   (memWData),
    .sbEmpty    (sbEmpty),
    .sbFull     (sbFull),
    .sbCount    (sbCount),
    .sbOverflow (sbOverflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    cpuAddr   = '0;
    cpuWe     = 1'b0;
    cpuWData  = '0;
    memRData  = 32'h55;
    memWReady = 1'b0;
    #3;
    chk("rst_empty", 32'(sbEmpty), 32'd1);
    chk("rst_full", 32'(sbFull), 32'd0);
    chk("rst_count", 32'(sbCount), 32'd0);
    chk("rst_wvalid", 32'(memWValid), 32'd0);
    chk("rst_ovf", 32'(sbOverflow), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // push two stores with the RAM stalled, then drain
    cpuWe = 1'b1; cpuAddr = 32'h10; cpuWData = 32'hA;
    tick();
    cpuAddr = 32'h14; cpuWData = 32'hB;
    tick();
    cpuWe = 1'b0; cpuAddr = 32'h0;
    #1;
    chk("pd_count2", 32'(sbCount), 32'd2);
    chk("pd_wvalid", 32'(memWValid), 32'd1);
    chk("pd_waddr", memWAddr, 32'h10);
    chk("pd_wdata", memWData, 32'hA);
    tick();
    chk("pd_waddr_hold", memWAddr, 32'h10);
    chk("pd_wdata_hold", memWData, 32'hA);
    memWReady = 1'b1;
    #1;
    chk("pd_drain0", memWData, 32'hA);
    tick();
    chk("pd_drain1", memWData, 32'hB);
    chk("pd_drain1_addr", memWAddr, 32'h14);
    chk("pd_count1", 32'(sbCount), 32'd1);
    tick();
    memWReady = 1'b0;
    #1;
    chk("pd_empty", 32'(sbEmpty), 32'd1);
    chk("pd_count0", 32'(sbCount), 32'd0);

    // forwarding: youngest of two stores to the same word
    cpuWe = 1'b1; cpuAddr = 32'h20; cpuWData = 32'h1;
    tick();
    cpuWData = 32'h2;
    tick();
    cpuWe = 1'b0; cpuAddr = 32'h20; memRData = 32'h55;
    #1;
    chk("fw_young", cpuRData, 32'h2);
    chk("fw_raddr", memRAddr, 32'h20);
    cpuAddr = 32'h24;
    #1;
    chk("fw_miss", cpuRData, 32'h55);
    cpuAddr = 32'h22;
    #1;
    chk("fw_lowbits", cpuRData, 32'h2);
    cpuAddr = 32'h20; memWReady = 1'b1;
    #1;
    chk("fw_during_pop", cpuRData, 32'h2);
    tick();
    chk("fw_last_popping", cpuRData, 32'h2);
    tick();
    memWReady = 1'b0;
    #1;
    chk("fw_after_drain", cpuRData, 32'h55);
    chk("fw_empty", 32'(sbEmpty), 32'd1);

    // wrap: ten stores with interleaved drains, pointers wrap twice
    for (int i = 0; i < 10; i++) begin
      cpuWe     = 1'b1;
      cpuAddr   = 32'h80 + 32'(4 * (i % 2));
      cpuWData  = 32'h100 + 32'(i);
      memWReady = (i % 3) != 0;
      tick();
    end
    cpuWe = 1'b0; memWReady = 1'b0; cpuAddr = 32'h80;
    #1;
    chk("wr_count", 32'(sbCount), 32'd4);
    chk("wr_full", 32'(sbFull), 32'd1);
    chk("wr_ovf", 32'(sbOverflow), 32'd0);
    chk("wr_head_addr", memWAddr, 32'h80);
    chk("wr_head_data", memWData, 32'h106);
    chk("wr_fwd80", cpuRData, 32'h108);
    cpuAddr = 32'h84;
    #1;
    chk("wr_fwd84", cpuRData, 32'h109);

    // full: a store with no drain is dropped
    cpuWe = 1'b1; cpuAddr = 32'h84; cpuWData = 32'hDEAD;
    tick();
    cpuWe = 1'b0;
    #1;
    chk("fl_ovf", 32'(sbOverflow), 32'd1);
    chk("fl_count", 32'(sbCount), 32'd4);
    chk("fl_dropped", cpuRData, 32'h109);
    // full with simultaneous drain accepts the store
    cpuWe = 1'b1; cpuAddr = 32'h88; cpuWData = 32'h77; memWReady = 1'b1;
    tick();
    cpuWe = 1'b0; memWReady = 1'b0;
    #1;
    chk("fl_count_same", 32'(sbCount), 32'd4);
    chk("fl_ovf_sticky", 32'(sbOverflow), 32'd1);
    chk("fl_head", memWData, 32'h107);
    chk("fl_fwd88", cpuRData, 32'h77);
    memWReady = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    memWReady = 1'b0;
    #1;
    chk("fl_drained", 32'(sbEmpty), 32'd1);

    // same-cycle store is not forwarded until the next cycle
    cpuWe = 1'b1; cpuAddr = 32'h30; cpuWData = 32'h7; memRData = 32'h0;
    #1;
    chk("sc_same", cpuRData, 32'h0);
    tick();
    cpuWe = 1'b0;
    #1;
    chk("sc_next", cpuRData, 32'h7);

    // asynchronous reset in the middle of a drain
    cpuWe = 1'b1; cpuAddr = 32'h34; cpuWData = 32'h8;
    tick();
    cpuAddr = 32'h38; cpuWData = 32'h9;
    tick();
    cpuWe = 1'b0; memWReady = 1'b1; cpuAddr = 32'h30;
    #1;
    chk("mr_count3", 32'(sbCount), 32'd3);
    rst = 1'b1;
    #1;
    chk("mr_empty", 32'(sbEmpty), 32'd1);
    chk("mr_wvalid", 32'(memWValid), 32'd0);
    chk("mr_count", 32'(sbCount), 32'd0);
    chk("mr_ovf", 32'(sbOverflow), 32'd0);
    tick();
    chk("mr_hold_empty", 32'(sbEmpty), 32'd1);
    rst = 1'b0; memWReady = 1'b0; memRData = 32'h66;
    #1;
    chk("mr_no_fwd", cpuRData, 32'h66);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
